// File: rtl/host_mem_rsp_router.sv
// Steers in-order host memory read beats and write responses back to the DMA or USM source.
// Define HOSTMEM_RSP_ROUTER_ERR_CHECK_EN to discard unexpected responses and build the sticky error flag.
module host_mem_rsp_router #(
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int ORDER_DEPTH     = 64,
  localparam int ORDER_DEPTH_W  = $clog2(ORDER_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_rd_fire,
  input  logic                       req_rd_src,
  input  logic [BURST_CNT_WIDTH-1:0] req_rd_burstcount,
  input  logic                       req_wr_fire,
  input  logic                       req_wr_src,
  output logic                       rd_order_full,
  output logic                       wr_order_full,
  input  logic                       sink_readdatavalid,
  input  logic [DATA_WIDTH-1:0]      sink_readdata,
  input  logic [1:0]                 sink_response,
  input  logic                       sink_writeresponsevalid,
  input  logic [1:0]                 sink_wr_response,
  output logic [1:0]                 src_readdatavalid,
  output logic [DATA_WIDTH-1:0]      src_readdata,
  output logic [1:0]                 src_response,
  output logic [1:0]                 src_writeresponsevalid,
  output logic [1:0]                 src_wr_response,
  output logic [ORDER_DEPTH_W:0]     rd_outstanding,
  output logic                       err_unexpected
);

  typedef struct packed {
    logic                       src;
    logic [BURST_CNT_WIDTH-1:0] len;
  } rd_entry_t;

  rd_entry_t                  rd_mem [ORDER_DEPTH];
  logic [ORDER_DEPTH_W-1:0]   rd_wptr, rd_rptr;
  logic [ORDER_DEPTH_W:0]     rd_count;
  logic [BURST_CNT_WIDTH-1:0] rd_beats;
  rd_entry_t                  rd_head;
  logic                       rd_empty, rd_full, rd_last, rd_pop, rd_push;
  logic [BURST_CNT_WIDTH-1:0] rd_len_in;

  logic [ORDER_DEPTH-1:0]     wr_mem;
  logic [ORDER_DEPTH_W-1:0]   wr_wptr, wr_rptr;
  logic [ORDER_DEPTH_W:0]     wr_count;
  logic                       wr_empty, wr_full, wr_pop, wr_push;

  logic [1:0]                 rd_valid_next, wr_valid_next;

  assign rd_head   = rd_mem[rd_rptr];
  assign rd_empty  = (rd_count == '0);
  assign rd_full   = (rd_count == (ORDER_DEPTH_W + 1)'(ORDER_DEPTH));
  // Beats already delivered for the head burst are counted upward, so the
  // next head takes effect on the very next beat without a reload cycle.
  assign rd_last   = ((rd_beats + BURST_CNT_WIDTH'(1)) == rd_head.len);
  assign rd_pop    = sink_readdatavalid && !rd_empty && rd_last;
  assign rd_push   = req_rd_fire && (!rd_full || rd_pop);
  assign rd_len_in = (req_rd_burstcount == '0) ? BURST_CNT_WIDTH'(1) : req_rd_burstcount;

  assign wr_empty  = (wr_count == '0);
  assign wr_full   = (wr_count == (ORDER_DEPTH_W + 1)'(ORDER_DEPTH));
  assign wr_pop    = sink_writeresponsevalid && !wr_empty;
  assign wr_push   = req_wr_fire && (!wr_full || wr_pop);

  assign rd_order_full  = rd_full;
  assign wr_order_full  = wr_full;
  assign rd_outstanding = rd_count;

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wptr] <= '{src: req_rd_src, len: rd_len_in};
    if (wr_push) wr_mem[wr_wptr] <= req_wr_src;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
      rd_beats <= '0;
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
    end else begin
      if (rd_push) rd_wptr <= rd_wptr + 1'b1;
      if (rd_pop)  rd_rptr <= rd_rptr + 1'b1;
      rd_count <= rd_count + (ORDER_DEPTH_W + 1)'(rd_push) - (ORDER_DEPTH_W + 1)'(rd_pop);
      if (sink_readdatavalid && !rd_empty)
        rd_beats <= rd_last ? '0 : rd_beats + BURST_CNT_WIDTH'(1);
      if (wr_push) wr_wptr <= wr_wptr + 1'b1;
      if (wr_pop)  wr_rptr <= wr_rptr + 1'b1;
      wr_count <= wr_count + (ORDER_DEPTH_W + 1)'(wr_push) - (ORDER_DEPTH_W + 1)'(wr_pop);
    end
  end

  always_comb begin
    rd_valid_next = '0;
    if (sink_readdatavalid) begin
      if (!rd_empty) rd_valid_next[rd_head.src] = 1'b1;
`ifndef HOSTMEM_RSP_ROUTER_ERR_CHECK_EN
      else rd_valid_next[0] = 1'b1;
`endif
    end
  end

  always_comb begin
    wr_valid_next = '0;
    if (sink_writeresponsevalid) begin
      if (!wr_empty) wr_valid_next[wr_mem[wr_rptr]] = 1'b1;
`ifndef HOSTMEM_RSP_ROUTER_ERR_CHECK_EN
      else wr_valid_next[0] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_readdatavalid      <= '0;
      src_readdata           <= '0;
      src_response           <= '0;
      src_writeresponsevalid <= '0;
      src_wr_response        <= '0;
    end else begin
      src_readdatavalid      <= rd_valid_next;
      src_readdata           <= sink_readdata;
      src_response           <= sink_response;
      src_writeresponsevalid <= wr_valid_next;
      src_wr_response        <= sink_wr_response;
    end
  end

`ifdef HOSTMEM_RSP_ROUTER_ERR_CHECK_EN
  logic err_q;
  logic err_event;

  assign err_event = (sink_readdatavalid && rd_empty)
                   || (sink_writeresponsevalid && wr_empty)
                   || (req_rd_fire && !rd_push)
                   || (req_wr_fire && !wr_push)
                   || (req_rd_fire && (req_rd_burstcount == '0));

  always_ff @(posedge clk) begin
    if (reset)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign err_unexpected = err_q;
`else
  assign err_unexpected = 1'b0;
`endif

endmodule

// File: tb/tb_host_mem_rsp_router.sv
// Randomized self-checking bench for host_mem_rsp_router against a per-beat source queue model.
module tb_host_mem_rsp_router;
  localparam int DW  = 32;
  localparam int BCW = 7;
  localparam int DEP = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_rd_fire, req_rd_src, req_wr_fire, req_wr_src;
  logic [BCW-1:0] req_rd_burstcount;
  logic           rd_order_full, wr_order_full;
  logic           sink_readdatavalid, sink_writeresponsevalid;
  logic [DW-1:0]  sink_readdata;
  logic [1:0]     sink_response, sink_wr_response;
  logic [1:0]     src_readdatavalid, src_response, src_writeresponsevalid, src_wr_response;
  logic [DW-1:0]  src_readdata;
  logic [2:0]     rd_outstanding;
  logic           err_unexpected;

  int tests = 0;
  int fails = 0;

`ifdef HOSTMEM_RSP_ROUTER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  host_mem_rsp_router #(.DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .ORDER_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .req_rd_fire(req_rd_fire), .req_rd_src(req_rd_src), .req_rd_burstcount(req_rd_burstcount),
    .req_wr_fire(req_wr_fire), .req_wr_src(req_wr_src),
    .rd_order_full(rd_order_full), .wr_order_full(wr_order_full),
    .sink_readdatavalid(sink_readdatavalid), .sink_readdata(sink_readdata),
    .sink_response(sink_response), .sink_writeresponsevalid(sink_writeresponsevalid),
    .sink_wr_response(sink_wr_response),
    .src_readdatavalid(src_readdatavalid), .src_readdata(src_readdata),
    .src_response(src_response), .src_writeresponsevalid(src_writeresponsevalid),
    .src_wr_response(src_wr_response), .rd_outstanding(rd_outstanding),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_rd_fire = 0; req_rd_src = 0; req_rd_burstcount = '0;
    req_wr_fire = 0; req_wr_src = 0;
    sink_readdatavalid = 0; sink_readdata = '0; sink_response = '0;
    sink_writeresponsevalid = 0; sink_wr_response = '0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset;
    logic [46:0] all_out;
    reset = 1; idle(); tick(); tick();
    all_out = {src_readdatavalid, src_writeresponsevalid, src_readdata, src_response,
               src_wr_response, rd_order_full, wr_order_full, rd_outstanding, err_unexpected};
    tests++;
    if (all_out !== '0) begin fails++; $display("FAIL reset_outputs got %h want 0", all_out); end
    reset = 0;
  endtask

  task automatic test_interleaved;
    logic [1:0] exp_v [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    bit         srcs [3]  = '{1'b0, 1'b1, 1'b0};
    int         lens [3]  = '{4, 2, 1};
    logic [DW-1:0] d;
    logic [1:0]    r;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_rd_fire = 1; req_rd_src = srcs[i]; req_rd_burstcount = BCW'(lens[i]);
      tick();
    end
    idle();
    tests++;
    if (rd_outstanding !== 3'd3) begin fails++; $display("FAIL il_outstanding got %0d want 3", rd_outstanding); end
    for (int i = 0; i < 7; i++) begin
      d = $urandom; r = 2'($urandom_range(0, 3));
      sink_readdatavalid = 1; sink_readdata = d; sink_response = r;
      tick();
      tests++;
      if (src_readdatavalid !== exp_v[i]) begin fails++; $display("FAIL il_valid beat %0d got %b want %b", i, src_readdatavalid, exp_v[i]); end
      tests++;
      if (src_readdata !== d || src_response !== r) begin fails++; $display("FAIL il_data beat %0d got %h/%0d want %h/%0d", i, src_readdata, src_response, d, r); end
    end
    idle(); tick();
    tests++;
    if (src_readdatavalid !== 2'b00 || rd_outstanding !== 3'd0) begin fails++; $display("FAIL il_drain got v=%b o=%0d want 00/0", src_readdatavalid, rd_outstanding); end
  endtask

  task automatic test_writes;
    bit         srcs [3]  = '{1'b1, 1'b0, 1'b1};
    logic [1:0] codes [3] = '{2'd0, 2'd2, 2'd0};
    logic [1:0] exp_v [3] = '{2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_wr_fire = 1; req_wr_src = srcs[i];
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      sink_writeresponsevalid = 1; sink_wr_response = codes[i];
      tick();
      tests++;
      if (src_writeresponsevalid !== exp_v[i] || src_wr_response !== codes[i]) begin
        fails++; $display("FAIL wr_rsp %0d got %b/%0d want %b/%0d", i, src_writeresponsevalid, src_wr_response, exp_v[i], codes[i]);
      end
    end
    idle();
  endtask

  task automatic test_full_boundary;
    bit q[$];
    bit s;
    logic [1:0] ev;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom); q.push_back(s);
      req_rd_fire = 1; req_rd_src = s; req_rd_burstcount = 1;
      tick();
    end
    req_rd_fire = 0;
    tests++;
    if (rd_order_full !== 1'b1 || rd_outstanding !== 3'd4) begin fails++; $display("FAIL full_set got f=%b o=%0d want 1/4", rd_order_full, rd_outstanding); end
    s = 1'($urandom);
    req_rd_fire = 1; req_rd_src = s; req_rd_burstcount = 1; sink_readdatavalid = 1;
    ev = 2'b01 << q.pop_front();
    q.push_back(s);
    tick();
    tests++;
    if (rd_order_full !== 1'b1 || rd_outstanding !== 3'd4 || src_readdatavalid !== ev) begin
      fails++; $display("FAIL full_pushpop got f=%b o=%0d v=%b want 1/4/%b", rd_order_full, rd_outstanding, src_readdatavalid, ev);
    end
    idle();
    req_rd_fire = 1; req_rd_src = 1; req_rd_burstcount = 1;
    tick();
    idle();
    tests++;
    if (rd_outstanding !== 3'd4 || err_unexpected !== ERR_EN) begin fails++; $display("FAIL full_drop got o=%0d e=%b want 4/%b", rd_outstanding, err_unexpected, ERR_EN); end
    for (int i = 0; i < 4; i++) begin
      sink_readdatavalid = 1;
      ev = 2'b01 << q.pop_front();
      tick();
      tests++;
      if (src_readdatavalid !== ev) begin fails++; $display("FAIL full_drain beat %0d got %b want %b", i, src_readdatavalid, ev); end
    end
    tests++;
    if (rd_order_full !== 1'b0 || rd_outstanding !== 3'd0) begin fails++; $display("FAIL full_clear got f=%b o=%0d want 0/0", rd_order_full, rd_outstanding); end
    tick();
    tests++;
    if (src_readdatavalid !== (ERR_EN ? 2'b00 : 2'b01)) begin fails++; $display("FAIL full_extra_beat got %b want %b", src_readdatavalid, ERR_EN ? 2'b00 : 2'b01); end
    idle();
  endtask

  task automatic test_unexpected;
    do_reset();
    sink_readdatavalid = 1;
    tick();
    idle();
    tests++;
    if (src_readdatavalid !== (ERR_EN ? 2'b00 : 2'b01) || err_unexpected !== ERR_EN) begin
      fails++; $display("FAIL unexp_rd got v=%b e=%b want %b/%b", src_readdatavalid, err_unexpected, ERR_EN ? 2'b00 : 2'b01, ERR_EN);
    end
    do_reset();
    sink_writeresponsevalid = 1; req_wr_fire = 1; req_wr_src = 1;
    tick();
    idle();
    tests++;
    if (src_writeresponsevalid !== (ERR_EN ? 2'b00 : 2'b01) || err_unexpected !== ERR_EN) begin
      fails++; $display("FAIL unexp_wr got v=%b e=%b want %b/%b", src_writeresponsevalid, err_unexpected, ERR_EN ? 2'b00 : 2'b01, ERR_EN);
    end
    sink_writeresponsevalid = 1;
    tick();
    idle();
    tests++;
    if (src_writeresponsevalid !== 2'b10) begin fails++; $display("FAIL unexp_wr_next got %b want 10", src_writeresponsevalid); end
  endtask

  task automatic test_zero_burst;
    do_reset();
    req_rd_fire = 1; req_rd_src = 1; req_rd_burstcount = '0;
    tick();
    idle();
    sink_readdatavalid = 1;
    tick();
    idle();
    tests++;
    if (src_readdatavalid !== 2'b10 || rd_outstanding !== 3'd0 || err_unexpected !== ERR_EN) begin
      fails++; $display("FAIL zero_burst got v=%b o=%0d e=%b want 10/0/%b", src_readdatavalid, rd_outstanding, err_unexpected, ERR_EN);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [46:0] all_out;
    do_reset();
    req_rd_fire = 1; req_rd_src = 0; req_rd_burstcount = 8;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      sink_readdatavalid = 1; sink_readdata = $urandom;
      tick();
      tests++;
      if (src_readdatavalid !== 2'b01) begin fails++; $display("FAIL mid_pre beat %0d got %b want 01", i, src_readdatavalid); end
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    all_out = {src_readdatavalid, src_writeresponsevalid, src_readdata, src_response,
               src_wr_response, rd_order_full, wr_order_full, rd_outstanding, err_unexpected};
    tests++;
    if (all_out !== '0) begin fails++; $display("FAIL mid_reset got %h want 0", all_out); end
    req_rd_fire = 1; req_rd_src = 1; req_rd_burstcount = 2;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      sink_readdatavalid = 1;
      tick();
      tests++;
      if (src_readdatavalid !== 2'b10) begin fails++; $display("FAIL mid_post beat %0d got %b want 10", i, src_readdatavalid); end
    end
    idle();
  endtask

  task automatic test_random_soak;
    bit rd_exp[$];
    bit wr_exp[$];
    int rd_issued = 0, wr_issued = 0, rd_avail = 0, wr_avail = 0, len = 0, cyc = 0;
    bit fire_rd, fire_wr, beat, wrsp, s, sw;
    logic [1:0] ev, ew, r, wc;
    logic [DW-1:0] d;
    do_reset();
    while ((rd_issued < 400 || wr_issued < 400 || rd_exp.size() > 0 || wr_exp.size() > 0) && cyc < 60000) begin
      cyc++;
      fire_rd = rd_issued < 400 && !rd_order_full && $urandom_range(0, 2) == 0;
      fire_wr = wr_issued < 400 && !wr_order_full && $urandom_range(0, 2) == 0;
      beat = rd_avail > 0 && $urandom_range(0, 3) != 0;
      wrsp = wr_avail > 0 && $urandom_range(0, 1) == 1;
      ev = beat ? (2'b01 << rd_exp.pop_front()) : 2'b00;
      ew = wrsp ? (2'b01 << wr_exp.pop_front()) : 2'b00;
      s = 1'($urandom); sw = 1'($urandom); len = $urandom_range(1, 64);
      d = $urandom; r = 2'($urandom); wc = 2'($urandom);
      if (fire_rd) begin
        rd_issued++;
        for (int k = 0; k < len; k++) rd_exp.push_back(s);
      end
      if (fire_wr) begin wr_issued++; wr_exp.push_back(sw); end
      req_rd_fire = fire_rd; req_rd_src = s; req_rd_burstcount = BCW'(len);
      req_wr_fire = fire_wr; req_wr_src = sw;
      sink_readdatavalid = beat; sink_readdata = d; sink_response = r;
      sink_writeresponsevalid = wrsp; sink_wr_response = wc;
      tick();
      if (beat) rd_avail--;
      if (wrsp) wr_avail--;
      if (fire_rd) rd_avail += len;
      if (fire_wr) wr_avail++;
      tests++;
      if (src_readdatavalid !== ev || (beat && (src_readdata !== d || src_response !== r))) begin
        fails++; $display("FAIL soak_rd cyc %0d got %b/%h want %b/%h", cyc, src_readdatavalid, src_readdata, ev, d);
      end
      tests++;
      if (src_writeresponsevalid !== ew || (wrsp && src_wr_response !== wc)) begin
        fails++; $display("FAIL soak_wr cyc %0d got %b/%0d want %b/%0d", cyc, src_writeresponsevalid, src_wr_response, ew, wc);
      end
    end
    idle();
    tests++;
    if (rd_exp.size() != 0 || wr_exp.size() != 0 || err_unexpected !== 1'b0) begin
      fails++; $display("FAIL soak_drain left rd=%0d wr=%0d err=%b want 0/0/0", rd_exp.size(), wr_exp.size(), err_unexpected);
    end
  endtask

  initial begin
    test_reset();
    test_interleaved();
    test_writes();
    test_full_boundary();
    test_unexpected();
    test_zero_burst();
    test_reset_mid_burst();
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
